alu_exec_unit: RTL

Registered execute-stage ALU that consumes the 4-bit `Operation` code from the ALU control decoder and the two register operands, and produces a result plus branch-compare flags. Logic and shift ops, add/sub and compares complete in one cycle. Multiply and divide run on an iterative shift-add/restoring engine with a start/busy/done handshake, so the pipeline stalls on `busy`.

---
 rtl/alu_exec_unit.sv | 308 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_exec_unit.sv
// ---------------------------------------------------------------------------
// alu_exec_unit
//
// Registered execute-stage ALU. Logic, shift, add/sub and compare operations
// finish one cycle after acceptance. Signed multiply and divide use an
// iterative shift-add / restoring engine. This engine runs for WIDTH cycles
// behind a start/busy/done handshake.
//
// Configuration macro:
//   ALU_MULDIV_EN  defined   -> iterative mul/div engine is built.
//                  undefined -> op codes 0010/0011 are illegal (single-cycle)
//                               and busy is tied low.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        request, sampled on the rising edge when accepted
//   Operation    4-bit op code from ALU control
//   a, b         operands (rs, rt/immediate)
//   shamt        shift amount for sll/srl (shifts operand b)
//   result       primary result (product low / quotient for mul/div)
//   hi           product high / remainder, 0 for other ops
//   zero         result == 0
//   negative     result MSB
//   overflow     signed overflow for add/sub/cmp
//   div_by_zero  div issued with b == 0
//   illegal      unsupported op code
//   busy         iterative operation in progress
//   done         one-cycle pulse per completed op, outputs valid
// ---------------------------------------------------------------------------
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       Operation,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [4:0]       shamt,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic             zero,
    output logic             negative,
    output logic             overflow,
    output logic             div_by_zero,
    output logic             illegal,
    output logic             busy,
    output logic             done
);

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0, OP_SUB  = 4'h1, OP_MUL  = 4'h2, OP_DIV  = 4'h3,
        OP_SLL  = 4'h4, OP_SRL  = 4'h5, OP_ADDU = 4'h6, OP_SUBU = 4'h7,
        OP_AND  = 4'h8, OP_OR   = 4'h9, OP_XOR  = 4'hA, OP_NOR  = 4'hB,
        OP_CMP  = 4'hC, OP_SGT  = 4'hD, OP_SLT  = 4'hE, OP_ILL  = 4'hF
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    op_e op;
    assign op = op_e'(Operation);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic             zero_q, zero_d;
    logic             neg_q, neg_d;
    logic             ovf_q, ovf_d;
    logic             dbz_q, dbz_d;
    logic             ill_q, ill_d;
    logic             complete;

    // Single-cycle datapath, evaluated on the live inputs.
    logic [WIDTH-1:0] sum, diff;
    logic             add_ovf, sub_ovf;
    logic [WIDTH-1:0] sc_res, sc_hi;
    logic             sc_ovf, sc_dbz, sc_ill;

    assign sum     = a + b;
    assign diff    = a - b;
    // Signed overflow: add when same-sign operands produce a different sign;
    // sub when opposite-sign operands produce a result whose sign differs from a.
    assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1]  != a[WIDTH-1]);
    assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);

    // NOTE: every variable driven in an always_comb gets a default before the
    // case statement. Any path that leaves it unassigned would infer a latch.
    always_comb begin
        sc_res = '0;
        sc_hi  = '0;
        sc_ovf = 1'b0;
        sc_dbz = 1'b0;
        sc_ill = 1'b0;
        case (op)
            OP_ADD:  begin sc_res = sum;  sc_ovf = add_ovf; end
            OP_SUB:  begin sc_res = diff; sc_ovf = sub_ovf; end
            OP_CMP:  begin sc_res = diff; sc_ovf = sub_ovf; end
            OP_ADDU: sc_res = sum;
            OP_SUBU: sc_res = diff;
            OP_SLL:  sc_res = b << shamt;
            OP_SRL:  sc_res = b >> shamt;
            OP_AND:  sc_res = a & b;
            OP_OR:   sc_res = a | b;
            OP_XOR:  sc_res = a ^ b;
            OP_NOR:  sc_res = ~(a | b);
            OP_SGT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(a) > $signed(b))};
            OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
`ifdef ALU_MULDIV_EN
            // A zero divisor bypasses the engine entirely.
            OP_DIV: begin
                if (b == '0) begin
                    sc_res = '1;
                    sc_hi  = a;
                    sc_dbz = 1'b1;
                end
            end
            OP_MUL:  ; // handled by the iterative engine
`else
            OP_MUL, OP_DIV: sc_ill = 1'b1;
`endif
            default: sc_ill = 1'b1;
        endcase
    end

`ifdef ALU_MULDIV_EN
    localparam int CW = $clog2(WIDTH + 1);

    // Shared engine registers. In mul, acc is the running high half and lo
    // holds the multiplier as it shifts out. In div, acc is the partial
    // remainder and lo shifts the dividend out while the quotient shifts in.
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;      // multiplicand / divisor magnitude
    logic             is_div_q, is_div_d;
    logic             sgn_q, sgn_d;      // sign of product / quotient
    logic             asgn_q, asgn_d;    // dividend sign -> remainder sign

    logic             is_iter;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   mul_sum, shifted, step_acc;
    logic [WIDTH-1:0] step_lo, quo, rem;
    logic [2*WIDTH-1:0] prod;

    assign is_iter = (op == OP_MUL) || ((op == OP_DIV) && (b != '0));
    assign a_mag   = a[WIDTH-1] ? -a : a;
    assign b_mag   = b[WIDTH-1] ? -b : b;

    // One engine iteration plus the sign fix-up of its outcome. The fix-up is
    // used only when the last iteration retires on the RUN->DONE edge.
    always_comb begin
        mul_sum = lo_q[0] ? (acc_q + {1'b0, dvs_q}) : acc_q;
        shifted = {acc_q[WIDTH-1:0], lo_q[WIDTH-1]};
        if (is_div_q) begin
            if (shifted >= {1'b0, dvs_q}) begin
                step_acc = shifted - {1'b0, dvs_q};
                step_lo  = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                step_acc = shifted;
                step_lo  = {lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            step_acc = {1'b0, mul_sum[WIDTH:1]};
            step_lo  = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
        prod = {step_acc[WIDTH-1:0], step_lo};
        if (sgn_q) begin
            prod = -prod;
        end
        quo = sgn_q  ? -step_lo : step_lo;
        rem = asgn_q ? -step_acc[WIDTH-1:0] : step_acc[WIDTH-1:0];
    end
`endif

    // Next-state and output-register logic.
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        hi_d     = hi_q;
        zero_d   = zero_q;
        neg_d    = neg_q;
        ovf_d    = ovf_q;
        dbz_d    = dbz_q;
        ill_d    = ill_q;
        complete = 1'b0;
`ifdef ALU_MULDIV_EN
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        lo_d     = lo_q;
        dvs_d    = dvs_q;
        is_div_d = is_div_q;
        sgn_d    = sgn_q;
        asgn_d   = asgn_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
`ifdef ALU_MULDIV_EN
                    if (is_iter) begin
                        state_d  = S_RUN;
                        cnt_d    = CW'(WIDTH);
                        acc_d    = '0;
                        lo_d     = a_mag;
                        dvs_d    = b_mag;
                        is_div_d = (op == OP_DIV);
                        sgn_d    = a[WIDTH-1] ^ b[WIDTH-1];
                        asgn_d   = a[WIDTH-1];
                    end else
`endif
                    begin
                        state_d  = S_DONE;
                        complete = 1'b1;
                        result_d = sc_res;
                        hi_d     = sc_hi;
                        ovf_d    = sc_ovf;
                        dbz_d    = sc_dbz;
                        ill_d    = sc_ill;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
`ifdef ALU_MULDIV_EN
            S_RUN: begin
                cnt_d = cnt_q - CW'(1);
                acc_d = step_acc;
                lo_d  = step_lo;
                if (cnt_q == CW'(1)) begin
                    state_d  = S_DONE;
                    complete = 1'b1;
                    result_d = is_div_q ? quo : prod[WIDTH-1:0];
                    hi_d     = is_div_q ? rem : prod[2*WIDTH-1:WIDTH];
                    ovf_d    = 1'b0;
                    dbz_d    = 1'b0;
                    ill_d    = 1'b0;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
        if (complete) begin
            zero_d = (result_d == '0);
            neg_d  = result_d[WIDTH-1];
        end
    end

    // NOTE: sequential state is written with non-blocking assignments, so
    // every register samples its _d value from before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            hi_q     <= '0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
            ovf_q    <= 1'b0;
            dbz_q    <= 1'b0;
            ill_q    <= 1'b0;
`ifdef ALU_MULDIV_EN
            cnt_q    <= '0;
            acc_q    <= '0;
            lo_q     <= '0;
            dvs_q    <= '0;
            is_div_q <= 1'b0;
            sgn_q    <= 1'b0;
            asgn_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            hi_q     <= hi_d;
            zero_q   <= zero_d;
            neg_q    <= neg_d;
            ovf_q    <= ovf_d;
            dbz_q    <= dbz_d;
            ill_q    <= ill_d;
`ifdef ALU_MULDIV_EN
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            lo_q     <= lo_d;
            dvs_q    <= dvs_d;
            is_div_q <= is_div_d;
            sgn_q    <= sgn_d;
            asgn_q   <= asgn_d;
`endif
        end
    end

    assign result      = result_q;
    assign hi          = hi_q;
    assign zero        = zero_q;
    assign negative    = neg_q;
    assign overflow    = ovf_q;
    assign div_by_zero = dbz_q;
    assign illegal     = ill_q;
    assign done        = (state_q == S_DONE);
`ifdef ALU_MULDIV_EN
    assign busy        = (state_q == S_RUN);
`else
    assign busy        = 1'b0;
`endif

endmodule
